// File: rtl/serie_paralelo_frame.sv
// Serial-to-parallel deserialiser with frame resync, valid/ready output
// register and a sticky overrun flag.
module serie_paralelo_frame #(
  parameter int  BITS      = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  input  logic            bit_valid,
  input  logic            frame_start,
  input  logic            out_ready,
  input  logic            overrun_clr,
  output logic [BITS-1:0] parallel_out,
  output logic            out_valid,
  output logic            overrun,
  output logic [CW-1:0]   bit_count
);

  logic [BITS-1:0] sh, sh_next;
  logic [CW-1:0]   cnt, idx;
  logic            last, complete, accept;

  // Next shift value, effective bit index and completion/handshake qualifiers
  always_comb begin
    idx      = frame_start ? '0 : cnt;
    sh_next  = MSB_FIRST ? {sh[BITS-2:0], serial_in} : {serial_in, sh[BITS-1:1]};
    last     = (idx == CW'(BITS-1));
    complete = bit_valid & last;
    accept   = out_valid & out_ready;
  end

  assign bit_count = cnt;

  // Shift register, bit counter, output word, handshake and overrun state
  always_ff @(posedge clk) begin
    if (reset) begin
      sh           <= '0;
      cnt          <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (bit_valid) begin
        sh  <= sh_next;
        cnt <= last ? '0 : idx + CW'(1);
      end
      // A completion always wins over an accept: the fresh word stays valid
      if (complete) begin
        parallel_out <= sh_next;
        out_valid    <= 1'b1;
      end else if (accept) begin
        out_valid    <= 1'b0;
      end
      // New overrun event takes priority over a clear in the same cycle
      if (complete && out_valid && !out_ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serie_paralelo_frame.sv
// Directed bench: one MSB-first and one LSB-first instance share all inputs.
module tb_serie_paralelo_frame;

  logic       clk = 1'b0;
  logic       reset, serial_in, bit_valid, frame_start, out_ready, overrun_clr;
  logic [7:0] po_m, po_l;
  logic       ov_m, ov_l, or_m, or_l;
  logic [2:0] bc_m, bc_l;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  serie_paralelo_frame #(.BITS(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(po_m), .out_valid(ov_m), .overrun(or_m), .bit_count(bc_m));

  serie_paralelo_frame #(.BITS(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(po_l), .out_valid(ov_l), .overrun(or_l), .bit_count(bc_l));

  // Drive one qualified bit, return 1 time unit after the sampling edge
  task automatic send_bit(input logic b, input logic fs);
    @(negedge clk);
    serial_in = b; bit_valid = 1'b1; frame_start = fs;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0; frame_start = 1'b0; serial_in = 1'b0;
    @(posedge clk); #1;
  endtask

  // Send w starting with w[7]; frame_start on the first bit if fs
  task automatic send_word(input logic [7:0] w, input logic fs);
    for (int i = 7; i >= 0; i--) send_bit(w[i], fs && (i == 7));
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; serial_in = 1'b1; bit_valid = 1'b1; frame_start = 1'b1;
    out_ready = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (po_m !== 8'h00 || ov_m !== 1'b0 || or_m !== 1'b0 || bc_m !== 3'd0) begin
      fails++; $display("FAIL reset_m: got po=%h v=%b o=%b bc=%0d exp 00 0 0 0", po_m, ov_m, or_m, bc_m); end
    tests++; if (po_l !== 8'h00 || ov_l !== 1'b0 || or_l !== 1'b0 || bc_l !== 3'd0) begin
      fails++; $display("FAIL reset_l: got po=%h v=%b o=%b bc=%0d exp 00 0 0 0", po_l, ov_l, or_l, bc_l); end
    @(negedge clk);
    reset = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_msb_basic();
    logic [7:0] w;
    logic [2:0] e;
    w = 8'hB4;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      e = (i == 7) ? 3'd0 : 3'(i + 1);
      tests++; if (bc_m !== e) begin
        fails++; $display("FAIL msb_bitcount[%0d]: got %0d exp %0d", i, bc_m, e); end
      if (i < 7) begin
        tests++; if (ov_m !== 1'b0) begin
          fails++; $display("FAIL msb_early_valid[%0d]: got %b exp 0", i, ov_m); end
      end
    end
    tests++; if (po_m !== 8'hB4 || ov_m !== 1'b1) begin
      fails++; $display("FAIL msb_word: got %h v=%b exp b4 v=1", po_m, ov_m); end
    tests++; if (po_l !== 8'h2D) begin
      fails++; $display("FAIL msb_word_lsb_inst: got %h exp 2d", po_l); end
    idle();
    tests++; if (ov_m !== 1'b0 || po_m !== 8'hB4) begin
      fails++; $display("FAIL msb_accept: got v=%b po=%h exp v=0 po=b4", ov_m, po_m); end
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] w;
    logic [2:0] e;
    w = 8'hB4;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      if (i < 7) begin
        e = 3'(i + 1);
        idle(); idle();
        tests++; if (bc_l !== e) begin
          fails++; $display("FAIL lsb_gap_hold[%0d]: got %0d exp %0d", i, bc_l, e); end
      end
    end
    tests++; if (po_l !== 8'h2D || ov_l !== 1'b1 || bc_l !== 3'd0) begin
      fails++; $display("FAIL lsb_word: got %h v=%b bc=%0d exp 2d v=1 bc=0", po_l, ov_l, bc_l); end
    idle();
    tests++; if (ov_l !== 1'b0) begin
      fails++; $display("FAIL lsb_accept: got v=%b exp 0", ov_l); end
  endtask

  task automatic test_resync();
    logic [7:0] w;
    w = 8'h01;
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    tests++; if (bc_m !== 3'd3) begin
      fails++; $display("FAIL resync_partial: got %0d exp 3", bc_m); end
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      if (i == 0) begin
        tests++; if (bc_m !== 3'd1) begin
          fails++; $display("FAIL resync_restart: got %0d exp 1", bc_m); end
      end
      if (i < 7) begin
        tests++; if (ov_m !== 1'b0) begin
          fails++; $display("FAIL resync_spurious[%0d]: got %b exp 0", i, ov_m); end
      end
    end
    tests++; if (po_m !== 8'h01 || ov_m !== 1'b1) begin
      fails++; $display("FAIL resync_word: got %h v=%b exp 01 v=1", po_m, ov_m); end
    tests++; if (po_l !== 8'h80) begin
      fails++; $display("FAIL resync_word_lsb: got %h exp 80", po_l); end
    idle();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_word(8'hB4, 1'b1);
    tests++; if (po_m !== 8'hB4 || ov_m !== 1'b1 || or_m !== 1'b0) begin
      fails++; $display("FAIL ovr_word1: got %h v=%b o=%b exp b4 1 0", po_m, ov_m, or_m); end
    send_word(8'h0F, 1'b0);
    tests++; if (po_m !== 8'h0F || ov_m !== 1'b1 || or_m !== 1'b1) begin
      fails++; $display("FAIL ovr_word2: got %h v=%b o=%b exp 0f 1 1", po_m, ov_m, or_m); end
    idle();
    tests++; if (or_m !== 1'b1) begin
      fails++; $display("FAIL ovr_sticky: got %b exp 1", or_m); end
    overrun_clr = 1'b1;
    idle();
    overrun_clr = 1'b0;
    tests++; if (or_m !== 1'b0 || ov_m !== 1'b1) begin
      fails++; $display("FAIL ovr_clear: got o=%b v=%b exp 0 1", or_m, ov_m); end
    // clear held through another overrunning completion: set must win
    overrun_clr = 1'b1;
    send_word(8'hAA, 1'b1);
    tests++; if (or_m !== 1'b1 || po_m !== 8'hAA) begin
      fails++; $display("FAIL ovr_set_wins: got o=%b po=%h exp 1 aa", or_m, po_m); end
    idle();
    overrun_clr = 1'b0;
    tests++; if (or_m !== 1'b0) begin
      fails++; $display("FAIL ovr_clear2: got %b exp 0", or_m); end
    out_ready = 1'b1;
    idle();
    tests++; if (ov_m !== 1'b0 || po_m !== 8'hAA) begin
      fails++; $display("FAIL ovr_accept: got v=%b po=%h exp 0 aa", ov_m, po_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'hC3;
    out_ready = 1'b0;
    send_word(8'h3C, 1'b1);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i == 7);
      send_bit(w[7-i], 1'b0);
    end
    tests++; if (po_m !== 8'hC3 || ov_m !== 1'b1 || or_m !== 1'b0) begin
      fails++; $display("FAIL b2b_accept_complete: got %h v=%b o=%b exp c3 1 0", po_m, ov_m, or_m); end
    idle();
    tests++; if (ov_m !== 1'b0) begin
      fails++; $display("FAIL b2b_final_accept: got %b exp 0", ov_m); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h53;
    out_ready = 1'b0;
    send_word(8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    tests++; if (bc_m !== 3'd5 || ov_m !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got bc=%0d v=%b exp 5 1", bc_m, ov_m); end
    @(negedge clk);
    reset = 1'b1; serial_in = 1'b1; bit_valid = 1'b1; frame_start = 1'b1;
    out_ready = 1'b1; overrun_clr = 1'b0;
    @(posedge clk); #1;
    tests++; if (po_m !== 8'h00 || ov_m !== 1'b0 || or_m !== 1'b0 || bc_m !== 3'd0) begin
      fails++; $display("FAIL rstmid_state: got po=%h v=%b o=%b bc=%0d exp 00 0 0 0", po_m, ov_m, or_m, bc_m); end
    @(negedge clk);
    reset = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], 1'b0);
      if (i == 6) begin
        tests++; if (bc_m !== 3'd7 || ov_m !== 1'b0) begin
          fails++; $display("FAIL rstmid_count: got bc=%0d v=%b exp 7 0", bc_m, ov_m); end
      end
    end
    tests++; if (po_m !== 8'h53 || ov_m !== 1'b1 || or_m !== 1'b0) begin
      fails++; $display("FAIL rstmid_word: got %h v=%b o=%b exp 53 1 0", po_m, ov_m, or_m); end
    tests++; if (po_l !== 8'hCA) begin
      fails++; $display("FAIL rstmid_word_lsb: got %h exp ca", po_l); end
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; overrun_clr = 1'b0;
    test_reset();
    test_msb_basic();
    test_lsb_gaps();
    test_resync();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serie_paralelo_frame.md
# serie_paralelo_frame

Parametrised serial-to-parallel deserialiser, successor to the fixed-width shift converter. Accepts one serial bit per qualified cycle, selectable MSB-first or LSB-first, with frame resynchronisation, a registered output word held under a valid/ready handshake, and a sticky overrun flag. Sits between a serial pin or bit-recovery stage and word-level consumer logic in the top-level wrapper.

## Interface
- BITS, 8, word width; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in parallel_out[BITS-1]; 0 = first received bit lands in parallel_out[0].
- CW, derived = clog2(BITS), width of bit_count; not user-set.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on clk rising edge.
- serial_in  in  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies serial_in for this cycle; gaps of any length allowed.
- frame_start  in  1  meaningful only with bit_valid=1; marks the current bit as bit 0 of a new word.
- out_ready  in  1  consumer accepts parallel_out when out_valid=1.
- overrun_clr  in  1  clears the overrun flag.
- parallel_out  out  BITS  last completed word, registered.
- out_valid  out  1  parallel_out holds an unaccepted word.
- overrun  out  1  sticky: a word completed while the previous word was still unaccepted.
- bit_count  out  CW  bits already collected in the current partial word (0..BITS-1).

## Operation
- Internal state: shift register sh[BITS-1:0], counter cnt, output register, out_valid, overrun.
- Cycle with bit_valid=1:
  - effective index idx = 0 if frame_start=1, else cnt. The partial word is discarded silently.
  - MSB_FIRST=1: sh_next = {sh[BITS-2:0], serial_in}. MSB_FIRST=0: sh_next = {serial_in, sh[BITS-1:1]}.
  - idx < BITS-1: cnt <= idx+1.
  - idx == BITS-1: word completes. cnt <= 0; parallel_out <= sh_next; out_valid <= 1.
- Cycle with bit_valid=0: sh and cnt hold. frame_start is ignored.
- Handshake:
  - Accept = out_valid & out_ready.
  - Accept without completion in the same cycle: out_valid <= 0; parallel_out holds its value.
  - Accept and completion in the same cycle: the new word loads, out_valid stays 1, no overrun.
- Overrun: completion while out_valid=1 and out_ready=0 sets overrun <= 1. The new word overwrites parallel_out; the old word is lost. out_valid stays 1.
- overrun_clr=1 clears overrun, unless a new overrun event occurs in the same cycle; set wins.
- bit_count = cnt, combinational from the register.
- Reset (any cycle, including mid-word or mid-handshake): sh=0, cnt=0, parallel_out=0, out_valid=0, overrun=0. All inputs are ignored in the reset cycle.

## Timing
- One bit per clk maximum; there is no back-pressure on the serial side.
- Latency: out_valid and the new parallel_out are visible immediately after the rising edge that samples the last bit (bit BITS-1) with bit_valid=1.
- Minimum spacing between completions: BITS cycles. Back-to-back words with no gap are supported.
- out_valid deasserts on the edge where accept is sampled.
- parallel_out changes only on a completion edge or a reset edge.
- overrun asserts on the edge of the overrun completion.

## Test plan
- MSB-first basic: BITS=8, MSB_FIRST=1, frame_start on the first bit, bits 1,0,1,1,0,1,0,0 on consecutive cycles, out_ready=1 -> parallel_out=0xB4, out_valid high for exactly 1 cycle, bit_count runs 1..7 then 0.
- LSB-first with gaps: BITS=8, MSB_FIRST=0, same bit sequence with bit_valid=0 idle cycles between bits -> parallel_out=0x2D after the 8th qualified bit; idle cycles leave bit_count unchanged.
- Resync: 3 bits 1,1,1, then frame_start with bits 0,0,0,0,0,0,0,1 (MSB-first) -> single completion with parallel_out=0x01; the partial 3-bit word is never output.
- Handshake and overrun: out_ready=0, send 0xB4 then 0x0F back-to-back -> after word 2, parallel_out=0x0F, out_valid=1, overrun=1. Pulse overrun_clr -> overrun=0. Raise out_ready -> out_valid=0 next edge.
- Simultaneous accept and completion: out_valid=1, out_ready=1 on the edge of the last bit of the next word -> out_valid stays 1, new word loaded, overrun stays 0.
- Reset mid-operation: reset after 5 bits with out_valid=1 -> all outputs 0 next edge. A full 8-bit word after reset (no frame_start) -> completes correctly with no contamination from the pre-reset bits.
